// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port front end for a single shared ALU.
//
// A request from one of two ports is granted in IDLE and its operands and
// opcode are captured into operand registers that drive the shared ALU. After
// one EXEC cycle the ALU result and zero flag are captured. The response is
// then presented to the granted port until it is accepted.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   req_valid/req_ready [1:0] - per-port request handshake (bit i = port i)
//   req_data1/req_data2       - per-port operands, port i at [i*WIDTH +: WIDTH]
//   req_op [7:0]              - per-port opcode, port i at [i*4 +: 4]
//   resp_valid/resp_ready     - per-port response handshake
//   resp_result, resp_zero    - registered ALU result and zero flag
//   alu_data1/2, alu_op       - operand registers driven to the shared ALU
//   alu_result, alu_zero      - combinational outputs of the shared ALU
//
// Configuration macro ALU_ARB_RR_EN:
//   defined   - round-robin between the ports, pointer flips on response exit
//   undefined - fixed priority, port 0 always wins a tie
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_data1,
  input  logic [2*WIDTH-1:0] req_data2,
  input  logic [7:0]         req_op,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_zero,
  output logic [WIDTH-1:0]   alu_data1,
  output logic [WIDTH-1:0]   alu_data2,
  output logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] data1_r;
  logic [WIDTH-1:0] data2_r;
  logic [3:0]       op_r;
  logic             grant_r;
  logic             winner_s;
  logic             req_hs_s;
  logic             resp_hs_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;

`ifdef ALU_ARB_RR_EN
  // Priority pointer: port favoured when both ports request together.
  logic prio_r;

  // Pointer update: the port just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (resp_hs_s) begin
      prio_r <= ~grant_r;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Round-robin winner selection; a lone requester always wins.
  always_comb begin
    winner_s = 1'b0;
    if (req_valid == 2'b11) begin
      winner_s = prio_r;
    end else if (req_valid[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`else
  // Fixed-priority winner selection: port 0 beats port 1.
  always_comb begin
    winner_s = 1'b0;
    if (req_valid[0]) begin
      winner_s = 1'b0;
    end else if (req_valid[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`endif

  // Next-state and handshake decode.
  always_comb begin
    state_s    = state_r;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    req_hs_s   = 1'b0;
    resp_hs_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Gated by rst_n so no ready is offered while reset is held.
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready = winner_s ? 2'b10 : 2'b01;
          req_hs_s  = 1'b1;
          state_s   = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        resp_valid = grant_r ? 2'b10 : 2'b01;
        // Only the granted port's resp_ready can complete the response.
        if (resp_ready[grant_r]) begin
          resp_hs_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on request handshake; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_r <= {WIDTH{1'b0}};
      data2_r <= {WIDTH{1'b0}};
      op_r    <= 4'b0000;
      grant_r <= 1'b0;
    end else if (req_hs_s) begin
      data1_r <= winner_s ? req_data1[2*WIDTH-1:WIDTH] : req_data1[WIDTH-1:0];
      data2_r <= winner_s ? req_data2[2*WIDTH-1:WIDTH] : req_data2[WIDTH-1:0];
      op_r    <= winner_s ? req_op[7:4] : req_op[3:0];
      grant_r <= winner_s;
    end else begin
      data1_r <= data1_r;
      data2_r <= data2_r;
      op_r    <= op_r;
      grant_r <= grant_r;
    end
  end

  // Result capture at the end of the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      result_r <= alu_result;
      zero_r   <= alu_zero;
    end else begin
      result_r <= result_r;
      zero_r   <= zero_r;
    end
  end

  assign alu_data1   = data1_r;
  assign alu_data2   = data2_r;
  assign alu_op      = op_r;
  assign resp_result = result_r;
  assign resp_zero   = zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data1;
  logic [63:0] req_data2;
  logic [7:0]  req_op;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;

  int checks;
  int errors;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_zero  (resp_zero),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the shared ALU that sits outside the arbiter.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_data1 + alu_data2;
      4'b0001: alu_result = alu_data1 - alu_data2;
      4'b0010: alu_result = alu_data1 & alu_data2;
      4'b0011: alu_result = alu_data1 | alu_data2;
      4'b0110: alu_result = (alu_data1 < alu_data2) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    req_data1  = 64'd0;
    req_data2  = 64'd0;
    req_op     = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    checks++; if (resp_result !== 32'd0 || resp_zero !== 1'b0) begin errors++; $display("FAIL reset_result got %h/%b want 0/0", resp_result, resp_zero); end
    checks++; if (alu_op !== 4'd0 || alu_data1 !== 32'd0 || alu_data2 !== 32'd0) begin errors++; $display("FAIL reset_alu got %h %h %h want 0", alu_op, alu_data1, alu_data2); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_port0();
    #1;
    req_valid = 2'b01;
    req_data1 = {32'd0, 32'd1};
    req_data2 = {32'd0, 32'd2};
    req_op    = 8'h00;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL p0_ready got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00 || alu_data1 !== 32'd1 || alu_data2 !== 32'd2) begin errors++; $display("FAIL p0_exec got %b %h %h want 00 1 2", resp_valid, alu_data1, alu_data2); end
    @(negedge clk);
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL p0_resp_valid got %b want 01", resp_valid); end
    checks++; if (resp_result !== 32'd3 || resp_zero !== 1'b0) begin errors++; $display("FAIL p0_result got %h/%b want 3/0", resp_result, resp_zero); end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL p0_done got %b want 00", resp_valid); end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL drop_ready got %b want 10", req_ready); end
    req_valid = 2'b00;
    repeat (3) begin
      @(negedge clk);
      checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL drop_idle got %b/%b want 00/00", resp_valid, req_ready); end
    end
  endtask

  task automatic test_port1();
    @(posedge clk); #1;
    req_valid = 2'b10;
    req_data1 = {32'd5, 32'd0};
    req_data2 = {32'd5, 32'd0};
    req_op    = 8'h10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL p1_ready got %b want 10", req_ready); end
    @(posedge clk); #1;
    // Port 0 now asks while the arbiter is busy and must be held off.
    req_valid = 2'b01;
    req_data1 = {32'd0, 32'd9};
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL p1_exec_ready got %b want 00", req_ready); end
    repeat (4) begin
      @(negedge clk);
      checks++; if (resp_valid !== 2'b10 || resp_result !== 32'd0 || resp_zero !== 1'b1 || req_ready !== 2'b00) begin
        errors++; $display("FAIL p1_hold got %b %h %b %b want 10 0 1 00", resp_valid, resp_result, resp_zero, req_ready);
      end
    end
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    req_valid  = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL p1_done got %b want 00", resp_valid); end
  endtask

  task automatic test_both();
    logic [1:0]  exp_port [4];
    logic [31:0] exp_res  [4];
`ifdef ALU_ARB_RR_EN
    exp_port = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_res  = '{32'h30, 32'hFC, 32'h30, 32'hFC};
`else
    exp_port = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_res  = '{32'h30, 32'h30, 32'h30, 32'h30};
`endif
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_data1 = {32'hF0, 32'hF0};
    req_data2 = {32'h3C, 32'h3C};
    req_op    = 8'h32;
    for (int t = 0; t < 4; t++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (resp_valid == 2'b00 && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      checks++; if (resp_valid !== exp_port[t] || resp_result !== exp_res[t]) begin
        errors++; $display("FAIL both_%0d got %b/%h want %b/%h", t, resp_valid, resp_result, exp_port[t], exp_res[t]);
      end
      resp_ready = exp_port[t];
      @(posedge clk); #1;
      resp_ready = 2'b00;
      if (t == 3) req_valid = 2'b00;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_data1 = {32'd0, 32'd1};
    req_data2 = {32'd0, 32'd2};
    req_op    = 8'h00;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 2'b00 || resp_result !== 32'd0 || alu_data1 !== 32'd0 || alu_op !== 4'd0) begin
      errors++; $display("FAIL mid_reset got %b %h %h %h want 00 0 0 0", resp_valid, resp_result, alu_data1, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL mid_no_resp got %b want 00", resp_valid); end
    end
    req_valid = 2'b11;
    req_data1 = {32'hF0, 32'hF0};
    req_data2 = {32'h3C, 32'h3C};
    req_op    = 8'h32;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_regrant got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 2'b01 || resp_result !== 32'h30) begin errors++; $display("FAIL mid_resp got %b/%h want 01/30", resp_valid, resp_result); end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    req_valid  = 2'b01;
    req_data1  = {32'd0, 32'd3};
    req_data2  = {32'd0, 32'd7};
    req_op     = 8'h06;
    resp_ready = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL spur_ready got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 2'b01 || resp_result !== 32'd1 || resp_zero !== 1'b0) begin
      errors++; $display("FAIL spur_resp got %b/%h/%b want 01/1/0", resp_valid, resp_result, resp_zero);
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL spur_done got %b want 00", resp_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_port0();
    test_drop();
    test_port1();
    test_both();
    test_reset_mid();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-port request valid (bit i = port i).
REQ-005 req_ready  output  2  per-port request accept; at most one bit set.
REQ-006 req_data1  input  2*WIDTH  per-port operand 1; port i in bits [i*WIDTH +: WIDTH].
REQ-007 req_data2  input  2*WIDTH  per-port operand 2, packed as req_data1.
REQ-008 req_op  input  8  per-port 4-bit ALU operation code; port i in bits [i*4 +: 4].
REQ-009 resp_valid  output  2  per-port response valid; at most one bit set.
REQ-010 resp_ready  input  2  per-port response accept.
REQ-011 resp_result  output  WIDTH  registered ALU result, shared by both ports.
REQ-012 resp_zero  output  1  registered ALU zero flag.
REQ-013 alu_data1, alu_data2  output  WIDTH  operands to the shared ALU.
REQ-014 alu_op  output  4  operation code to the shared ALU, passed through unmodified; decode belongs to the ALU.
REQ-015 alu_result  input  WIDTH, alu_zero  input  1  combinational ALU outputs.

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid bit is set, req_ready is asserted combinationally to the single winner in the same cycle.
REQ-018 A handshake occurs when req_valid & req_ready; on it, the winner's data1, data2 and op are latched into operand registers, the grant index is stored, and the FSM moves to EXEC.
REQ-019 alu_data1, alu_data2 and alu_op are driven from the operand registers in every state, so they hold their last value.
REQ-020 EXEC lasts exactly one cycle; at its end, alu_result and alu_zero are registered into resp_result and resp_zero, and the FSM moves to RESP.
REQ-021 RESP: resp_valid is asserted only for the granted port; resp_result and resp_zero hold stable until resp_ready is seen on that port, then the FSM returns to IDLE.
REQ-022 Latency: request handshake in cycle N, resp_valid rises in cycle N+2; there is no IDLE bypass, so minimum spacing between grants is 3 cycles.
REQ-023 req_ready is 0 in EXEC and RESP; requests arriving there wait.
REQ-024 A requester may drop req_valid before handshake; no grant, no state change.
REQ-025 resp_ready on the non-granted port is ignored.
REQ-026 Only one port requesting: that port wins regardless of priority state.
REQ-027 Both ports requesting simultaneously: the winner is chosen by the priority rule in REQ-031/032.

Reset
REQ-028 When rst_n is low: FSM state IDLE; req_ready=0; resp_valid=0; resp_result=0; resp_zero=0; operand registers=0; alu_op=0; grant index=0; priority pointer=port 0.
REQ-029 Reset asserted mid-operation (EXEC or RESP) discards the transaction with no response delivered; the first grant after reset follows REQ-028 priority.

Configuration
REQ-030 Macro ALU_ARB_RR_EN selects the arbitration policy.
REQ-031 ALU_ARB_RR_EN defined: round-robin; the priority pointer flips to the other port on each completed response handshake (RESP exit), so the port just served has lowest priority.
REQ-032 ALU_ARB_RR_EN undefined: fixed priority with port 0 always winning; no pointer register exists.

Verification
REQ-033 Port 0 only: data1=1, data2=2, op=0000 -> req_ready[0] in cycle N, resp_valid[0] in N+2, result=3, zero=0.
REQ-034 Port 1 only: data1=5, data2=5, op=0001 -> resp_valid[1], result=0, zero=1; resp_ready held low 4 cycles -> result stable, resp_valid held.
REQ-035 Both valid continuously: port 0 op=0010 (0xF0 & 0x3C), port 1 op=0011 (0xF0 | 0x3C).
  With RR: grant order 0,1,0,1; results 0x30, 0xFC alternate.
  Without RR: port 0 only; results 0x30 repeated.
REQ-036 rst_n pulsed low during EXEC -> resp_valid stays 0 and all outputs return to reset values; next request is granted normally.
REQ-037 Port 0 requests op=0110 with data1=3, data2=7 while port 1 raises resp_ready spuriously -> port 1 input ignored; resp_valid[0] with result=1.
